pend_enc8to3: RTL and testbench
===============================

# pend_enc8to3

Sequential 8-to-3 encoder: the transmit-side counterpart to the team's 3-to-8 decoders. It accepts an 8-bit multi-hot request vector and emits one 3-bit index per handshake, in fixed priority order, until every set bit has been encoded. Downstream, each emitted code can drive a `dec3to8`-style decoder to regenerate one one-hot line at a time. Typical use is serialising simultaneous requests onto a narrow index bus.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 = lowest set bit index is emitted first; 0 = highest set bit index first.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_req` is presented.
- `in_ready`  output  1  block can accept a new vector this cycle.
- `in_req`  input  8  multi-hot request vector.
- `out_valid`  output  1  `out_code` holds a valid index.
- `out_ready`  input  1  downstream consumes `out_code` this cycle.
- `out_code`  output  3  binary index of the current highest-priority pending bit.
- `out_last`  output  1  the current code is the final pending bit of the vector.
- `out_cnt`  output  4  number of bits still pending (0–8).

## Operation
- The only state is the 8-bit register `pending`. Two implied states:
  - IDLE when `pending` == 0.
  - DRAIN when `pending` != 0.
- Accept: a vector is accepted when `in_valid` && `in_ready`. On that edge, `pending` <= `in_req`.
- Zero vector: an accepted `in_req` of 8'h00 is consumed silently. No code is emitted and the block stays IDLE.
- `in_ready` = (`pending` == 0) || (`out_valid` && `out_ready` && `out_last`). Both terms are combinational.
- Output signals, all combinational from `pending` (no input-to-output path except through `in_ready`):
  - `out_valid` = (`pending` != 0).
  - `out_code` = priority-selected set bit index. When `out_valid` is 0, `out_code` = 3'd0.
  - `out_last` = `out_valid` && exactly one bit of `pending` is set.
  - `out_cnt` = popcount(`pending`).
- Consume: on `out_valid` && `out_ready`, the bit at `out_code` is cleared in `pending`.
- Back-to-back reload: if the last bit is consumed and a new vector is accepted in the same cycle, `pending` <= `in_req`. The new vector takes the place of the cleared bit, giving no bubble.
- Stall: while `out_valid` && !`out_ready`, `out_code`, `out_last` and `out_cnt` hold stable.
- `in_req` is ignored whenever `in_ready` is 0. The block never merges vectors.

## Timing
- Reset values: `pending` = 0, `in_ready` = 1, `out_valid` = 0, `out_code` = 0, `out_last` = 0, `out_cnt` = 0.
- Reset is asynchronous. Asserting it mid-DRAIN clears `pending` immediately; outputs fall without waiting for `clk`.
- Latency: a vector accepted at edge N presents its first code in the cycle after edge N. That is one cycle, accept to first `out_valid`.
- Throughput: one code per cycle while `out_ready` = 1.
- A k-bit vector drains in k cycles. The next vector can be accepted on the k-th consume edge.
- `out_cnt` decrements by exactly 1 per consume and never wraps below 0.
- Maximum drain is 8 cycles, for `in_req` = 8'hFF.

## Test plan
- Reset, then `in_req` = 8'hA5 with `LSB_FIRST` = 1 and `out_ready` held 1:
  - codes 0, 2, 5, 7 on consecutive cycles;
  - `out_last` = 1 only with code 7;
  - `out_cnt` reads 4, 3, 2, 1.
- `LSB_FIRST` = 0 with `in_req` = 8'h81 -> code 7, then code 0 with `out_last` = 1; then `in_ready` = 1 and `out_valid` = 0.
- `in_req` = 8'h06, `out_ready` low for 3 cycles:
  - code 1 holds stable and `in_ready` stays 0;
  - a second `in_valid` pulse with 8'hFF during the stall is ignored;
  - after `out_ready` is raised, codes 1 then 2 are emitted.
- Back-to-back reload: while consuming the last bit of 8'h10 (code 4, `out_last` = 1), present `in_req` = 8'h03 in the same cycle. It is accepted, and codes 0 then 1 follow with no idle cycle.
- Zero vector: accept 8'h00 -> `out_valid` stays 0 and `in_ready` stays 1.
- Reset mid-drain: load 8'hFF, consume 3 codes, then assert `rst` asynchronously between edges. All outputs return to reset values before the next edge, and 8'h02 loaded after release yields code 1 only.

Source files
------------

// File: rtl/pend_enc8to3.sv
// rtl/pend_enc8to3.sv - sequential 8-to-3 encoder, one index per handshake in fixed priority
module pend_enc8to3 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic       out_last,
    output logic [3:0] out_cnt
);

    logic [7:0] pending;
    logic [2:0] sel_code;
    logic [3:0] pop_cnt;
    logic       consume;
    logic       accept;

    // Priority pick: the last matching bit in scan order wins.
    always_comb begin
        sel_code = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) sel_code = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) sel_code = 3'(i);
            end
        end
    end

    always_comb begin
        pop_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop_cnt = pop_cnt + 4'(pending[i]);
        end
    end

    assign out_valid = (pending != 8'h00);
    assign out_code  = sel_code;
    assign out_cnt   = pop_cnt;
    assign out_last  = out_valid && (pop_cnt == 4'd1);
    assign consume   = out_valid && out_ready;
    assign in_ready  = !out_valid || (consume && out_last);
    assign accept    = in_valid && in_ready;

    // A load always wins: in_ready only allows it once the last bit is leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 8'h00;
        end else if (accept) begin
            pending <= in_req;
        end else if (consume) begin
            pending <= pending & ~(8'b1 << sel_code);
        end
    end

endmodule

// File: tb/tb_pend_enc8to3.sv
// tb/tb_pend_enc8to3.sv - directed self-checking bench for pend_enc8to3
module tb_pend_enc8to3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, out_last_a;
    logic [2:0] out_code_a;
    logic [3:0] out_cnt_a;
    logic       in_ready_b, out_valid_b, out_last_b;
    logic [2:0] out_code_b;
    logic [3:0] out_cnt_b;

    int checks = 0;
    int failures = 0;

    pend_enc8to3 #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_req(in_req), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_code(out_code_a), .out_last(out_last_a), .out_cnt(out_cnt_a)
    );

    pend_enc8to3 #(.LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_req(in_req), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_code(out_code_b), .out_last(out_last_b), .out_cnt(out_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [2:0] c,
                         input logic l, input logic [3:0] n, input logic r);
        chk({tag, ".valid"}, 8'(out_valid_a), 8'(v));
        chk({tag, ".code"},  8'(out_code_a),  8'(c));
        chk({tag, ".last"},  8'(out_last_a),  8'(l));
        chk({tag, ".cnt"},   8'(out_cnt_a),   8'(n));
        chk({tag, ".ready"}, 8'(in_ready_a),  8'(r));
    endtask

    initial begin
        #2;
        chk_a("reset", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
        step();
        rst = 1'b0;

        // 8'hA5 drains lowest-first
        in_req = 8'hA5; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        chk_a("a5_c0", 1'b1, 3'd0, 1'b0, 4'd4, 1'b0);
        step();
        chk_a("a5_c2", 1'b1, 3'd2, 1'b0, 4'd3, 1'b0);
        step();
        chk_a("a5_c5", 1'b1, 3'd5, 1'b0, 4'd2, 1'b0);
        step();
        chk_a("a5_c7", 1'b1, 3'd7, 1'b1, 4'd1, 1'b1);
        step();
        chk_a("a5_idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

        // 8'h81 on the highest-first instance
        in_req = 8'h81; in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        chk("msb_c7.code", 8'(out_code_b), 8'd7);
        chk("msb_c7.last", 8'(out_last_b), 8'd0);
        chk("msb_c7.cnt",  8'(out_cnt_b),  8'd2);
        step();
        chk("msb_c0.code", 8'(out_code_b), 8'd0);
        chk("msb_c0.last", 8'(out_last_b), 8'd1);
        step();
        chk("msb_idle.ready", 8'(in_ready_b), 8'd1);
        chk("msb_idle.valid", 8'(out_valid_b), 8'd0);

        // stall with an ignored 8'hFF pulse
        out_ready = 1'b0;
        in_req = 8'h06; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_a("stall", 1'b1, 3'd1, 1'b0, 4'd2, 1'b0);
            if (i == 1) begin
                in_req = 8'hFF; in_valid_a = 1'b1;
            end
            step();
            in_valid_a = 1'b0;
        end
        chk_a("stall_end", 1'b1, 3'd1, 1'b0, 4'd2, 1'b0);
        out_ready = 1'b1;
        step();
        chk_a("stall_c2", 1'b1, 3'd2, 1'b1, 4'd1, 1'b1);
        step();
        chk_a("stall_idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

        // back-to-back reload on the last consume
        in_req = 8'h10; in_valid_a = 1'b1;
        step();
        chk_a("b2b_c4", 1'b1, 3'd4, 1'b1, 4'd1, 1'b1);
        in_req = 8'h03;
        step();
        in_valid_a = 1'b0;
        chk_a("b2b_c0", 1'b1, 3'd0, 1'b0, 4'd2, 1'b0);
        step();
        chk_a("b2b_c1", 1'b1, 3'd1, 1'b1, 4'd1, 1'b1);
        step();
        chk_a("b2b_idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

        // zero vector is swallowed
        in_req = 8'h00; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        chk_a("zero", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

        // asynchronous reset mid-drain
        in_req = 8'hFF; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        chk_a("ff_c0", 1'b1, 3'd0, 1'b0, 4'd8, 1'b0);
        step(); step(); step();
        chk_a("ff_c3", 1'b1, 3'd3, 1'b0, 4'd5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_a("async_rst", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
        #1;
        rst = 1'b0;
        in_req = 8'h02; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        chk_a("post_rst_c1", 1'b1, 3'd1, 1'b1, 4'd1, 1'b1);
        step();
        chk_a("post_rst_idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
